// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the LEGv8 MEM stage: FSM states, MEM/WB
// register layout and its cleared value, default access timeout.
package memory_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem2reg;
        logic [4:0]  rd;
        logic [63:0] mem_data;
        logic [63:0] alu_out;
    } memwb_t;

    localparam memwb_t MEMWB_BUBBLE = '0;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/memory_stage_wait_timer.sv
// Counts cycles spent waiting on a data-memory ack and flags when the
// configured timeout count has been reached.
module memory_stage_wait_timer
    import memory_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic run,
    input  logic wait_active,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter reads 1 during the first WAIT cycle; any cycle neither starting nor running clears it.
    always_comb begin
        cnt_d = '0;
        if (start) begin
            cnt_d = CNT_W'(1);
        end else if (run) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = wait_active && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/memory_stage.sv
// LEGv8 MEM stage: branch resolve, req/ack data-memory access with timeout,
// upstream stall and MEM/WB register. MEMSTAGE_PERF_EN adds perf counters.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_MEM,
    input  logic        Branch_MEM,
    input  logic        Uncondbranch_MEM,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic        Mem2Reg_MEM,
    input  logic        ALUzero_MEM,
    input  logic [4:0]  RD_MEM,
    input  logic [63:0] RegOutB_MEM,
    input  logic [63:0] ALUout_MEM,
    input  logic [63:0] PCtarget_MEM,
    output logic        PCSrc_MEM,
    output logic [63:0] PCtarget_IF,
    output logic        Stall_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        dmem_err,
`ifdef MEMSTAGE_PERF_EN
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores,
    output logic [31:0] perf_stalls,
`endif
    output logic        RegWrite_WB,
    output logic        Mem2Reg_WB,
    output logic [4:0]  RD_WB,
    output logic [63:0] MemData_WB,
    output logic [63:0] ALUout_WB
);

    mem_state_t state_q, state_d;
    memwb_t     wb_q, wb_d;
    logic       err_q, err_d;
    logic       access, is_load, complete, timeout_now, expired;
    logic       tmr_start, tmr_run;

    assign PCSrc_MEM   = Uncondbranch_MEM | (Branch_MEM & ALUzero_MEM);
    assign PCtarget_IF = PCtarget_MEM;

    always_comb begin
        access      = MemRead_MEM | MemWrite_MEM;
        is_load     = MemRead_MEM & ~MemWrite_MEM;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        dmem_addr   = '0;
        dmem_wdata  = '0;
        timeout_now = 1'b0;
        if (!reset) begin
            dmem_req    = (state_q == WAIT) | access;
            dmem_we     = dmem_req & MemWrite_MEM;
            dmem_addr   = ALUout_MEM;
            dmem_wdata  = RegOutB_MEM;
            timeout_now = expired & ~dmem_ack;
        end
        complete  = dmem_req & dmem_ack;
        Stall_MEM = dmem_req & ~dmem_ack & ~timeout_now;
        tmr_start = (state_q == IDLE) & Stall_MEM;
        tmr_run   = (state_q == WAIT) & Stall_MEM;

        state_d = state_q;
        case (state_q)
            IDLE: if (Stall_MEM) state_d = WAIT;
            WAIT: if (complete || timeout_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        err_d = err_q | timeout_now;

        // Stall and timeout both write a bubble; data fields hold their last value.
        wb_d = wb_q;
        if (Stall_MEM || timeout_now) begin
            wb_d.reg_write = 1'b0;
            wb_d.mem2reg   = 1'b0;
        end else begin
            wb_d.reg_write = RegWrite_MEM & ~(MemRead_MEM & MemWrite_MEM);
            wb_d.mem2reg   = Mem2Reg_MEM;
            wb_d.rd        = RD_MEM;
            wb_d.alu_out   = ALUout_MEM;
            if (is_load && complete) wb_d.mem_data = dmem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wb_q    <= MEMWB_BUBBLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
            err_q   <= err_d;
        end
    end

    memory_stage_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_wait_timer (
        .clk         (clk),
        .reset       (reset),
        .start       (tmr_start),
        .run         (tmr_run),
        .wait_active (state_q == WAIT),
        .expired     (expired)
    );

`ifdef MEMSTAGE_PERF_EN
    logic [31:0] perf_loads_q, perf_loads_d;
    logic [31:0] perf_stores_q, perf_stores_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_loads_d  = perf_loads_q  + {31'b0, complete & is_load};
        perf_stores_d = perf_stores_q + {31'b0, complete & MemWrite_MEM};
        perf_stalls_d = perf_stalls_q + {31'b0, Stall_MEM};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_loads_q  <= '0;
            perf_stores_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_loads_q  <= perf_loads_d;
            perf_stores_q <= perf_stores_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_loads  = perf_loads_q;
    assign perf_stores = perf_stores_q;
    assign perf_stalls = perf_stalls_q;
`endif

    assign dmem_err    = err_q;
    assign RegWrite_WB = wb_q.reg_write;
    assign Mem2Reg_WB  = wb_q.mem2reg;
    assign RD_WB       = wb_q.rd;
    assign MemData_WB  = wb_q.mem_data;
    assign ALUout_WB   = wb_q.alu_out;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage (default build, timeout 16).
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_MEM, Branch_MEM, Uncondbranch_MEM;
    logic        MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM, ALUzero_MEM;
    logic [4:0]  RD_MEM;
    logic [63:0] RegOutB_MEM, ALUout_MEM, PCtarget_MEM;
    logic        PCSrc_MEM;
    logic [63:0] PCtarget_IF;
    logic        Stall_MEM, dmem_req, dmem_we, dmem_ack, dmem_err;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        RegWrite_WB, Mem2Reg_WB;
    logic [4:0]  RD_WB;
    logic [63:0] MemData_WB, ALUout_WB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_stage #(
        .TIMEOUT_CYCLES (16),
        .CNT_W          (5)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .RegWrite_MEM     (RegWrite_MEM),
        .Branch_MEM       (Branch_MEM),
        .Uncondbranch_MEM (Uncondbranch_MEM),
        .MemRead_MEM      (MemRead_MEM),
        .MemWrite_MEM     (MemWrite_MEM),
        .Mem2Reg_MEM      (Mem2Reg_MEM),
        .ALUzero_MEM      (ALUzero_MEM),
        .RD_MEM           (RD_MEM),
        .RegOutB_MEM      (RegOutB_MEM),
        .ALUout_MEM       (ALUout_MEM),
        .PCtarget_MEM     (PCtarget_MEM),
        .PCSrc_MEM        (PCSrc_MEM),
        .PCtarget_IF      (PCtarget_IF),
        .Stall_MEM        (Stall_MEM),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .dmem_err         (dmem_err),
        .RegWrite_WB      (RegWrite_WB),
        .Mem2Reg_WB       (Mem2Reg_WB),
        .RD_WB            (RD_WB),
        .MemData_WB       (MemData_WB),
        .ALUout_WB        (ALUout_WB)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        RegWrite_MEM = 0; Branch_MEM = 0; Uncondbranch_MEM = 0;
        MemRead_MEM = 0; MemWrite_MEM = 0; Mem2Reg_MEM = 0; ALUzero_MEM = 0;
        RD_MEM = 0; RegOutB_MEM = 0; ALUout_MEM = 0; PCtarget_MEM = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1;
        MemRead_MEM = 1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0) begin
            errors++; $display("FAIL reset_req_gated: got %b expected 0", dmem_req);
        end
        checks++;
        if ({RegWrite_WB, Mem2Reg_WB, RD_WB, MemData_WB, ALUout_WB} !== '0) begin
            errors++; $display("FAIL reset_wb: got %b %b %h %h %h expected all 0",
                               RegWrite_WB, Mem2Reg_WB, RD_WB, MemData_WB, ALUout_WB);
        end
        checks++;
        if (dmem_err !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b expected 0", dmem_err);
        end
        tick();
        reset = 0;
        clear_inputs();
    endtask

    task automatic test_rtype;
        RegWrite_MEM = 1; RD_MEM = 3; ALUout_MEM = 64'h2A;
        @(negedge clk);
        checks++;
        if (Stall_MEM !== 1'b0 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL rtype_no_stall: got stall=%b req=%b expected 0 0", Stall_MEM, dmem_req);
        end
        tick();
        checks++;
        if (RegWrite_WB !== 1'b1 || RD_WB !== 5'd3 || ALUout_WB !== 64'h2A) begin
            errors++; $display("FAIL rtype_wb: got rw=%b rd=%0d alu=%h expected 1 3 2a",
                               RegWrite_WB, RD_WB, ALUout_WB);
        end
    endtask

    task automatic test_load_wait;
        RegWrite_MEM = 1; Mem2Reg_MEM = 1; MemRead_MEM = 1;
        RD_MEM = 5; ALUout_MEM = 64'h100; dmem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (Stall_MEM !== 1'b1 || dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 64'h100) begin
                errors++; $display("FAIL load_wait_cycle%0d: got stall=%b req=%b we=%b addr=%h expected 1 1 0 100",
                                   i, Stall_MEM, dmem_req, dmem_we, dmem_addr);
            end
            tick();
            checks++;
            if (RegWrite_WB !== 1'b0 || Mem2Reg_WB !== 1'b0 || RD_WB !== 5'd3) begin
                errors++; $display("FAIL load_bubble%0d: got rw=%b m2r=%b rd=%0d expected 0 0 3",
                                   i, RegWrite_WB, Mem2Reg_WB, RD_WB);
            end
        end
        dmem_ack = 1; dmem_rdata = 64'hDEAD;
        @(negedge clk);
        checks++;
        if (Stall_MEM !== 1'b0) begin
            errors++; $display("FAIL load_ack_stall: got %b expected 0", Stall_MEM);
        end
        tick();
        clear_inputs();
        checks++;
        if (MemData_WB !== 64'hDEAD || Mem2Reg_WB !== 1'b1 || RegWrite_WB !== 1'b1 || RD_WB !== 5'd5) begin
            errors++; $display("FAIL load_wb: got data=%h m2r=%b rw=%b rd=%0d expected dead 1 1 5",
                               MemData_WB, Mem2Reg_WB, RegWrite_WB, RD_WB);
        end
    endtask

    task automatic test_store;
        MemWrite_MEM = 1; ALUout_MEM = 64'h80; RegOutB_MEM = 64'h55; dmem_ack = 1;
        @(negedge clk);
        checks++;
        if (dmem_we !== 1'b1 || dmem_req !== 1'b1 || Stall_MEM !== 1'b0 ||
            dmem_addr !== 64'h80 || dmem_wdata !== 64'h55) begin
            errors++; $display("FAIL store_bus: got we=%b req=%b stall=%b addr=%h wdata=%h expected 1 1 0 80 55",
                               dmem_we, dmem_req, Stall_MEM, dmem_addr, dmem_wdata);
        end
        tick();
        checks++;
        if (RegWrite_WB !== 1'b0 || MemData_WB !== 64'hDEAD) begin
            errors++; $display("FAIL store_wb: got rw=%b data=%h expected 0 dead", RegWrite_WB, MemData_WB);
        end
        // Read and write together behave as a store with write-back suppressed.
        MemRead_MEM = 1; RegWrite_MEM = 1; dmem_rdata = 64'h99;
        @(negedge clk);
        checks++;
        if (dmem_we !== 1'b1) begin
            errors++; $display("FAIL rw_both_we: got %b expected 1", dmem_we);
        end
        tick();
        checks++;
        if (RegWrite_WB !== 1'b0 || MemData_WB !== 64'hDEAD) begin
            errors++; $display("FAIL rw_both_wb: got rw=%b data=%h expected 0 dead", RegWrite_WB, MemData_WB);
        end
        clear_inputs();
    endtask

    task automatic test_branch;
        Branch_MEM = 1; ALUzero_MEM = 1; PCtarget_MEM = 64'h40;
        #1;
        checks++;
        if (PCSrc_MEM !== 1'b1 || PCtarget_IF !== 64'h40) begin
            errors++; $display("FAIL branch_taken: got pcsrc=%b tgt=%h expected 1 40", PCSrc_MEM, PCtarget_IF);
        end
        ALUzero_MEM = 0;
        #1;
        checks++;
        if (PCSrc_MEM !== 1'b0) begin
            errors++; $display("FAIL branch_not_taken: got %b expected 0", PCSrc_MEM);
        end
        Branch_MEM = 0; Uncondbranch_MEM = 1;
        #1;
        checks++;
        if (PCSrc_MEM !== 1'b1) begin
            errors++; $display("FAIL uncond_branch: got %b expected 1", PCSrc_MEM);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout;
        int stalls = 0;
        MemRead_MEM = 1; RegWrite_MEM = 1; Mem2Reg_MEM = 1; RD_MEM = 7; ALUout_MEM = 64'h200;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (Stall_MEM === 1'b1) stalls++;
            tick();
        end
        checks++;
        if (stalls != 16) begin
            errors++; $display("FAIL timeout_stall_count: got %0d expected 16", stalls);
        end
        @(negedge clk);
        checks++;
        if (Stall_MEM !== 1'b0 || dmem_req !== 1'b1 || dmem_err !== 1'b0) begin
            errors++; $display("FAIL timeout_cycle: got stall=%b req=%b err=%b expected 0 1 0",
                               Stall_MEM, dmem_req, dmem_err);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (dmem_err !== 1'b1 || dmem_req !== 1'b0 || RegWrite_WB !== 1'b0 || MemData_WB !== 64'hDEAD) begin
            errors++; $display("FAIL timeout_after: got err=%b req=%b rw=%b data=%h expected 1 0 0 dead",
                               dmem_err, dmem_req, RegWrite_WB, MemData_WB);
        end
        RegWrite_MEM = 1; RD_MEM = 9; ALUout_MEM = 64'h1;
        tick();
        clear_inputs();
        checks++;
        if (dmem_err !== 1'b1 || RegWrite_WB !== 1'b1 || RD_WB !== 5'd9) begin
            errors++; $display("FAIL err_sticky_idle: got err=%b rw=%b rd=%0d expected 1 1 9",
                               dmem_err, RegWrite_WB, RD_WB);
        end
    endtask

    task automatic test_reset_in_wait;
        MemRead_MEM = 1; RegWrite_MEM = 1; RD_MEM = 4; ALUout_MEM = 64'h300;
        tick();
        tick();
        reset = 1;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || Stall_MEM !== 1'b0) begin
            errors++; $display("FAIL reset_wait_req: got req=%b stall=%b expected 0 0", dmem_req, Stall_MEM);
        end
        tick();
        reset = 0;
        clear_inputs();
        checks++;
        if ({RegWrite_WB, Mem2Reg_WB, RD_WB, MemData_WB, ALUout_WB, dmem_err} !== '0) begin
            errors++; $display("FAIL reset_wait_wb: got rw=%b m2r=%b rd=%0d data=%h alu=%h err=%b expected all 0",
                               RegWrite_WB, Mem2Reg_WB, RD_WB, MemData_WB, ALUout_WB, dmem_err);
        end
        dmem_ack = 1; dmem_rdata = 64'hBEEF;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || Stall_MEM !== 1'b0) begin
            errors++; $display("FAIL stray_ack_req: got req=%b stall=%b expected 0 0", dmem_req, Stall_MEM);
        end
        tick();
        clear_inputs();
        checks++;
        if (MemData_WB !== 64'h0 || RegWrite_WB !== 1'b0) begin
            errors++; $display("FAIL stray_ack_wb: got data=%h rw=%b expected 0 0", MemData_WB, RegWrite_WB);
        end
    endtask

    task automatic test_back_to_back;
        MemRead_MEM = 1; Mem2Reg_MEM = 1; RegWrite_MEM = 1; RD_MEM = 10;
        ALUout_MEM = 64'h10; dmem_ack = 1; dmem_rdata = 64'h11;
        @(negedge clk);
        checks++;
        if (Stall_MEM !== 1'b0) begin
            errors++; $display("FAIL b2b_first_stall: got %b expected 0", Stall_MEM);
        end
        tick();
        checks++;
        if (MemData_WB !== 64'h11 || RD_WB !== 5'd10 || ALUout_WB !== 64'h10) begin
            errors++; $display("FAIL b2b_first_wb: got data=%h rd=%0d alu=%h expected 11 10 10",
                               MemData_WB, RD_WB, ALUout_WB);
        end
        RD_MEM = 11; ALUout_MEM = 64'h18; dmem_rdata = 64'h22;
        tick();
        clear_inputs();
        checks++;
        if (MemData_WB !== 64'h22 || RD_WB !== 5'd11 || RegWrite_WB !== 1'b1 || Mem2Reg_WB !== 1'b1) begin
            errors++; $display("FAIL b2b_second_wb: got data=%h rd=%0d rw=%b m2r=%b expected 22 11 1 1",
                               MemData_WB, RD_WB, RegWrite_WB, Mem2Reg_WB);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_store();
        test_branch();
        test_timeout();
        test_reset_in_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
